// File: rtl/team_06_pkg.sv
// Shared register map, STATUS bit layout and default window base for the
// Wishbone peripheral.
package team_06_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

    localparam logic [7:0] OFF_SCRATCH = 8'h00;
    localparam logic [7:0] OFF_LED     = 8'h04;
    localparam logic [7:0] OFF_TIMER   = 8'h08;
    localparam logic [7:0] OFF_TXDATA  = 8'h0C;
    localparam logic [7:0] OFF_STATUS  = 8'h10;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_COUNT_LSB = 2;
    localparam int STAT_COUNT_W   = 5;
    localparam int STAT_OVF       = 8;

    typedef enum logic [2:0] {
        REG_SCRATCH,
        REG_LED,
        REG_TIMER,
        REG_TXDATA,
        REG_STATUS,
        REG_NONE
    } reg_e;

    function automatic reg_e decode_offset(input logic [7:0] off);
        case (off)
            OFF_SCRATCH: return REG_SCRATCH;
            OFF_LED:     return REG_LED;
            OFF_TIMER:   return REG_TIMER;
            OFF_TXDATA:  return REG_TXDATA;
            OFF_STATUS:  return REG_STATUS;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/team_06_byte_fifo.sv
// Byte FIFO with power-of-two depth; a pop frees a slot for a push in the same
// cycle, so a full FIFO accepts a push when it is also being drained.
module team_06_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic [4:0] count
);
    import team_06_pkg::*;

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_STEP = AW'(1);
    localparam logic [4:0]    CNT_FULL = 5'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == 5'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? 8'h00 : mem[rd_ptr];

    // NOTE: the storage array is deliberately left without reset; only the
    // pointers and count are cleared, and head is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_STEP;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_STEP;
            case ({do_push, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/team_06_wb_periph.sv
// Wishbone classic slave: scratch, LED, free-running timer and a TX byte FIFO
// streamed out over valid/ready. Single-cycle registered acknowledge.
module team_06_wb_periph
    import team_06_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] led_o,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    input  logic        byte_ready_i
);

    logic [31:0] scratch;
    logic [31:0] timer;
    logic        ovf;
    logic        req;
    logic        wr;
    reg_e        reg_sel;
    logic [31:0] rdata;
    logic        push_req;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [4:0]  fifo_count;

    // Requests are taken only while ack is low, so each access acks exactly once.
    assign req      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o
                      & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign wr       = req & wbs_we_i;
    assign reg_sel  = decode_offset(wbs_adr_i[7:0]);
    assign push_req = wr & (reg_sel == REG_TXDATA) & wbs_sel_i[0];
    assign pop      = byte_valid_o & byte_ready_i;
    assign byte_valid_o = ~fifo_empty;

    team_06_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push_req),
        .push_data (wbs_dat_i[7:0]),
        .pop       (pop),
        .head      (byte_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // NOTE: defaulting rdata before the case keeps this purely combinational.
    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_SCRATCH: rdata = scratch;
            REG_LED:     rdata = {16'h0000, led_o};
            REG_TIMER:   rdata = timer;
            REG_STATUS: begin
                rdata[STAT_EMPTY]                          = fifo_empty;
                rdata[STAT_FULL]                           = fifo_full;
                rdata[STAT_COUNT_LSB +: STAT_COUNT_W]      = fifo_count;
                rdata[STAT_OVF]                            = ovf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            scratch   <= '0;
            led_o     <= '0;
            timer     <= '0;
            ovf       <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            // Write acks return zero data; reads return the addressed register.
            wbs_dat_o <= (req & ~wbs_we_i) ? rdata : '0;
            timer     <= (wr && reg_sel == REG_TIMER) ? '0 : timer + 32'd1;

            if (wr && reg_sel == REG_SCRATCH) begin
                for (int i = 0; i < 4; i++)
                    if (wbs_sel_i[i]) scratch[8*i +: 8] <= wbs_dat_i[8*i +: 8];
            end
            if (wr && reg_sel == REG_LED) begin
                for (int i = 0; i < 2; i++)
                    if (wbs_sel_i[i]) led_o[8*i +: 8] <= wbs_dat_i[8*i +: 8];
            end

            if (push_req && fifo_full && !pop)
                ovf <= 1'b1;
            else if (wr && reg_sel == REG_STATUS && wbs_dat_i[STAT_OVF])
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_team_06_wb_periph.sv
// Randomised + directed bench for team_06_wb_periph with a scoreboard of
// expected read data and a queue model of the TX byte stream.
`timescale 1ns/1ps
module tb_team_06_wb_periph;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, dat_w = '0;
    logic [3:0]  sel = '0;
    logic        ack;
    logic [31:0] dat_r;
    logic [15:0] led;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b0;

    team_06_wb_periph #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (dat_w),
        .wbs_sel_i    (sel),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (dat_r),
        .led_o        (led),
        .byte_o       (byte_out),
        .byte_valid_o (byte_valid),
        .byte_ready_i (byte_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_scratch = '0;
    logic [15:0] m_led     = '0;
    logic [7:0]  m_fifo[$];
    bit          m_ovf     = 1'b0;
    int          edge_cnt  = 0;
    int          clear_edge = 0;

    always @(posedge clk) edge_cnt++;

    // Value a read accepted at the next rising edge should return.
    function automatic logic [31:0] model_read(input logic [7:0] off);
        int n;
        n = m_fifo.size();
        case (off)
            8'h00: return m_scratch;
            8'h04: return {16'h0000, m_led};
            8'h08: return 32'(edge_cnt - clear_edge);
            8'h10: return (32'(m_ovf) << 8) | (32'(n) << 2)
                          | (32'(n == DEPTH) << 1) | 32'(n == 0);
            default: return 32'h0;
        endcase
    endfunction

    // Applied just after the edge that accepted the write.
    task automatic model_write(input logic [7:0] off, input logic [31:0] d, input logic [3:0] s);
        case (off)
            8'h00: for (int i = 0; i < 4; i++) if (s[i]) m_scratch[8*i +: 8] = d[8*i +: 8];
            8'h04: for (int i = 0; i < 2; i++) if (s[i]) m_led[8*i +: 8] = d[8*i +: 8];
            8'h08: clear_edge = edge_cnt;
            8'h0C: if (s[0]) begin
                       if (m_fifo.size() < DEPTH) m_fifo.push_back(d[7:0]);
                       else m_ovf = 1'b1;
                   end
            8'h10: if (d[8]) m_ovf = 1'b0;
            default: ;
        endcase
    endtask

    // ---------------- scoreboard + monitors ----------------
    typedef struct {
        bit          chk;
        logic [7:0]  off;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    logic prev_ack = 1'b0;

    always @(negedge clk) begin
        if (ack) begin
            check("ack_single_cycle", 32'(prev_ack), 32'd0);
            if (sb.size() == 0) fail_now("unexpected_ack");
            else begin
                e = sb.pop_front();
                if (e.chk) check($sformatf("rdata_off%02h", e.off), dat_r, e.dat);
            end
        end else begin
            check("dat_zero_without_ack", dat_r, 32'd0);
        end
        prev_ack = ack;
    end

    always @(negedge clk) begin
        if (nrst) begin
            check("byte_valid", 32'(byte_valid), 32'(m_fifo.size() != 0));
            if (byte_valid && byte_ready) begin
                if (m_fifo.size() == 0) fail_now("stream_extra_byte");
                else check("stream_byte", 32'(byte_out), 32'(m_fifo.pop_front()));
            end
        end
    end

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            byte_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- driver ----------------
    task automatic wb_xfer(input bit w, input logic [7:0] off, input logic [31:0] d,
                           input logic [3:0] s, input bit decoded = 1'b1, input bit pulse = 1'b0);
        exp_t x;
        int   waits;
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = w; dat_w = d; sel = s;
        adr = decoded ? (BASE | 32'(off)) : ((BASE + 32'h100) | 32'(off));
        if (pulse) byte_ready = 1'b1;
        if (decoded) begin
            x.chk = !w;
            x.off = off;
            x.dat = model_read(off);
            sb.push_back(x);
        end
        waits = 0;
        do begin
            @(posedge clk);
            #1;
            waits++;
            if (pulse) byte_ready = 1'b0;
        end while (!ack && waits < 16);
        if (decoded) begin
            check("ack_latency", 32'(waits), 32'd1);
            if (w) model_write(off, d, s);
            check("led_out", 32'(led), 32'(m_led));
        end else begin
            check("undecoded_no_ack", 32'(ack), 32'd0);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    logic [7:0] offs [8];
    logic [7:0] r_off;
    bit         r_we;

    initial begin
        offs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'hFC};

        // Reset state
        #1;
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_dat", dat_r, 32'd0);
        check("reset_led", 32'(led), 32'd0);
        check("reset_valid", 32'(byte_valid), 32'd0);
        check("reset_byte", 32'(byte_out), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        clear_edge = edge_cnt;

        // Byte-lane write to SCRATCH
        wb_xfer(1, 8'h00, 32'hDEAD_BEEF, 4'b0101);
        wb_xfer(0, 8'h00, 32'h0, 4'hF);
        check("scratch_lane_model", m_scratch, 32'h00AD_00EF);

        // Timer clear then idle count; undecoded access
        wb_xfer(1, 8'h08, 32'h1234_5678, 4'hF);
        repeat (10) @(posedge clk);
        wb_xfer(0, 8'h08, 32'h0, 4'hF);
        wb_xfer(0, 8'h00, 32'h0, 4'hF, 1'b0);
        wb_xfer(1, 8'h00, 32'hFFFF_FFFF, 4'hF, 1'b0);
        wb_xfer(0, 8'h00, 32'h0, 4'hF);

        // LED lanes, upper half reads zero; unlisted offset
        wb_xfer(1, 8'h04, 32'hCAFE_A55A, 4'b0011);
        wb_xfer(1, 8'h04, 32'h0000_7700, 4'b0010);
        wb_xfer(0, 8'h04, 32'h0, 4'hF);
        wb_xfer(1, 8'h14, 32'hFFFF_FFFF, 4'hF);
        wb_xfer(0, 8'h14, 32'h0, 4'hF);

        // Fill past full with consumer stalled
        byte_ready = 1'b0;
        for (int i = 1; i <= 9; i++) wb_xfer(1, 8'h0C, 32'(i), 4'b0001);
        wb_xfer(0, 8'h10, 32'h0, 4'hF);
        check("status_after_overflow", model_read(8'h10), 32'h0000_0122);
        wb_xfer(0, 8'h0C, 32'h0, 4'hF);

        // Drain on consecutive cycles, then W1C of OVF
        byte_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("drain_valid", 32'(byte_valid), 32'd1);
        end
        @(negedge clk);
        check("drain_done", 32'(byte_valid), 32'd0);
        wb_xfer(0, 8'h10, 32'h0, 4'hF);
        wb_xfer(1, 8'h10, 32'h0000_0100, 4'hF);
        wb_xfer(0, 8'h10, 32'h0, 4'hF);

        // Full FIFO with push and pop in the same cycle
        byte_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) wb_xfer(1, 8'h0C, 32'(8'h10 + i), 4'b0001);
        wb_xfer(1, 8'h0C, 32'h0000_00A5, 4'b0001, 1'b1, 1'b1);
        wb_xfer(0, 8'h10, 32'h0, 4'hF);
        wb_xfer(1, 8'h0C, 32'h0000_00EE, 4'b0000);
        byte_ready = 1'b1;
        repeat (DEPTH + 4) @(posedge clk);
        #1;
        byte_ready = 1'b0;
        wb_xfer(0, 8'h10, 32'h0, 4'hF);

        // Randomised traffic with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r_off = offs[$urandom_range(0, 7)];
            r_we  = 1'($urandom_range(0, 1));
            if (r_off == 8'h10) r_we = 1'b1;
            wb_xfer(r_we, r_off, $urandom, 4'($urandom_range(0, 15)));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        byte_ready = 1'b0;
        wb_xfer(0, 8'h10, 32'h0, 4'hF);
        byte_ready = 1'b1;
        repeat (DEPTH + 4) @(posedge clk);
        #1;
        byte_ready = 1'b0;
        wb_xfer(0, 8'h10, 32'h0, 4'hF);

        // Reset in the middle of a read
        wb_xfer(1, 8'h00, 32'h1234_5678, 4'hF);
        wb_xfer(1, 8'h04, 32'h0000_FFFF, 4'b0011);
        wb_xfer(1, 8'h0C, 32'h0000_0042, 4'b0001);
        wb_xfer(1, 8'h0C, 32'h0000_0043, 4'b0001);
        @(posedge clk);
        #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
        #2;
        nrst = 1'b0;
        m_scratch = '0; m_led = '0; m_fifo.delete(); m_ovf = 1'b0;
        #1;
        check("midreset_ack", 32'(ack), 32'd0);
        check("midreset_dat", dat_r, 32'd0);
        check("midreset_led", 32'(led), 32'd0);
        check("midreset_valid", 32'(byte_valid), 32'd0);
        check("midreset_byte", 32'(byte_out), 32'd0);
        @(posedge clk);
        #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        clear_edge = edge_cnt;
        repeat (4) begin
            @(negedge clk);
            check("post_reset_no_ack", 32'(ack), 32'd0);
        end
        wb_xfer(0, 8'h00, 32'h0, 4'hF);
        wb_xfer(0, 8'h08, 32'h0, 4'hF);
        repeat (3) @(posedge clk);

        if (sb.size() != 0) fail_now("scoreboard_not_empty");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
